hazard_ctrl: RTL

Pipeline scheduler for the five-stage ARM core: sits beside the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers and decides, every cycle, whether the PC and pipeline registers load, whether the control-unit mux injects a NOP, whether IF/ID is flushed after a taken branch, and which stage feeds each ID operand (forwarding selects). It drives the `LE` / `s` style signals the top level currently hard-wires, and keeps saturating stall/flush counters for debug.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_ctrl_fwd_select.sv | 41 ++++
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encoding,
// forwarding-select codes and the PC register number.
package hazard_pkg;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LDSTALL = 2'd1;
    localparam logic [1:0] ST_FREEZE  = 2'd2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam int PC_REG = 15;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Forwarding priority match for one ID operand; also flags a load-use
// dependency on that operand.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rf_en,
    input  logic             ex_load,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_rf_en,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_rf_en,
    output logic [1:0]       sel,
    output logic             load_hit
);

    logic active;

    // R15 is the PC and is never forwarded or interlocked.
    assign active = use_src && (src != REG_W'(PC_REG));

    always_comb begin
        sel = FWD_RF;
        if (active) begin
            if (ex_rf_en && !ex_load && (ex_rd == src)) begin
                sel = FWD_EX;
            end else if (mem_rf_en && (mem_rd == src)) begin
                sel = FWD_MEM;
            end else if (wb_rf_en && (wb_rd == src)) begin
                sel = FWD_WB;
            end
        end
    end

    assign load_hit = active && ex_rf_en && ex_load && (ex_rd == src);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline scheduler: load enables, NOP injection, branch flush and
// forwarding selects for the five-stage core, plus debug event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rd,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rf_en,
    input  logic             ex_load,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_rf_en,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_rf_en,
    input  logic             branch_taken,
    input  logic             freeze_req,
    input  logic             clr_cnt,
    output logic             pc_le,
    output logic             ifid_le,
    output logic             pipe_le,
    output logic             cu_nop,
    output logic             ifid_flush,
    output logic [1:0]       fwd_rn,
    output logic [1:0]       fwd_rm,
    output logic [1:0]       fwd_rd,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    logic [1:0] state_q, state_d;
    logic [1:0] sel_rn, sel_rm, sel_rd;
    logic       hit_rn, hit_rm, hit_rd;
    logic       load_use;
    logic       stall_inc, flush_inc;

    fwd_select #(.REG_W(REG_W)) u_fwd_rn (
        .src(id_rn), .use_src(id_use_rn),
        .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .ex_load(ex_load),
        .mem_rd(mem_rd), .mem_rf_en(mem_rf_en),
        .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
        .sel(sel_rn), .load_hit(hit_rn)
    );

    fwd_select #(.REG_W(REG_W)) u_fwd_rm (
        .src(id_rm), .use_src(id_use_rm),
        .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .ex_load(ex_load),
        .mem_rd(mem_rd), .mem_rf_en(mem_rf_en),
        .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
        .sel(sel_rm), .load_hit(hit_rm)
    );

    fwd_select #(.REG_W(REG_W)) u_fwd_rd (
        .src(id_rd), .use_src(id_use_rd),
        .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .ex_load(ex_load),
        .mem_rd(mem_rd), .mem_rf_en(mem_rf_en),
        .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
        .sel(sel_rd), .load_hit(hit_rd)
    );

    assign load_use = hit_rn || hit_rm || hit_rd;

    always_comb begin
        state_d    = state_q;
        pc_le      = 1'b1;
        ifid_le    = 1'b1;
        pipe_le    = 1'b1;
        cu_nop     = 1'b0;
        ifid_flush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        case (state_q)
            ST_LDSTALL: begin
                if (branch_taken) begin
                    ifid_flush = 1'b1;
                    flush_inc  = 1'b1;
                end
                state_d = freeze_req ? ST_FREEZE : ST_RUN;
            end
            // RUN, and FREEZE on the cycle freeze_req drops, share the RUN rules.
            default: begin
                state_d = ST_RUN;
                if (freeze_req) begin
                    pc_le   = 1'b0;
                    ifid_le = 1'b0;
                    pipe_le = 1'b0;
                    state_d = ST_FREEZE;
                end else if (load_use) begin
                    pc_le     = 1'b0;
                    ifid_le   = 1'b0;
                    cu_nop    = 1'b1;
                    stall_inc = 1'b1;
                    state_d   = ST_LDSTALL;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                    flush_inc  = 1'b1;
                end
            end
        endcase
        if (!reset) begin
            pc_le      = 1'b0;
            ifid_le    = 1'b0;
            pipe_le    = 1'b0;
            cu_nop     = 1'b1;
            ifid_flush = 1'b0;
            stall_inc  = 1'b0;
            flush_inc  = 1'b0;
            state_d    = ST_RUN;
        end
    end

    assign fwd_rn = reset ? sel_rn : FWD_RF;
    assign fwd_rm = reset ? sel_rm : FWD_RF;
    assign fwd_rd = reset ? sel_rd : FWD_RF;
    assign state  = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (clr_cnt) begin
                stall_cnt <= '0;
                flush_cnt <= '0;
            end else begin
                if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
                if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
